bp_fe_queue_fifo: RTL and testbench
===================================

BP_FE_QUEUE_FIFO -- requirements
Module: bp_fe_queue_fifo

Interface
REQ-001 The parameter els_p SHALL default to 8 and set the entry count; it SHALL be a power of two, at least 2.
REQ-002 The parameter width_p SHALL default to 128 and set the bit width of one fe_queue message.
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  reset, synchronous and active-high.
REQ-005 clr_i  input  1  flush request; empties the queue on a non-attaboy fe_cmd.
REQ-006 data_i  input  width_p  fe_queue message from pc_gen.
REQ-007 v_i  input  1  data_i valid.
REQ-008 ready_o  output  1  queue can accept data_i this cycle (drives pc_gen fe_queue_ready_i).
REQ-009 data_o  output  width_p  oldest message.
REQ-010 v_o  output  1  data_o valid.
REQ-011 yumi_i  input  1  consumer takes data_o this cycle; legal only when v_o=1.
REQ-012 count_o  output  $clog2(els_p+1)  number of stored entries.

Function
REQ-013 Storage SHALL be a circular buffer of els_p entries with read and write pointers of $clog2(els_p) bits that wrap from els_p-1 to 0.
REQ-014 Full/empty SHALL be distinguished by count (or a wrap bit), never by pointer equality alone.
REQ-015 ready_o SHALL be 1 exactly when count < els_p and depend only on registered state, never on v_i or yumi_i.
REQ-016 Enqueue SHALL occur when v_i & ready_o & ~clr_i: data_i is written at the write pointer and the write pointer advances by 1.
REQ-017 v_i while ready_o=0 SHALL be ignored, with no state change.
REQ-018 Dequeue SHALL occur when yumi_i & v_o & ~clr_i, and the read pointer SHALL advance by 1.
REQ-019 data_o SHALL equal the entry at the read pointer whenever v_o=1.
REQ-020 With the bypass feature disabled, v_o SHALL equal (count != 0), giving 1-cycle enqueue-to-visible latency.
REQ-021 On simultaneous enqueue and dequeue, count SHALL be unchanged and both pointers SHALL advance.
REQ-022 When full, enqueue SHALL be blocked even if yumi_i=1 the same cycle; ready_o rises the cycle after the dequeue.
REQ-023 clr_i SHALL take priority over everything else: the next cycle has count=0, pointers equal, v_o=0 and ready_o=1.
REQ-024 In the clr_i cycle, any enqueue and any dequeue SHALL be discarded.
REQ-025 count_o SHALL be updated as count + enq - deq, with no overflow or underflow under legal stimulus.
REQ-026 Message order SHALL be strictly FIFO, with no reordering and no duplication.
REQ-027 Simulation assertions SHALL flag yumi_i & ~v_o, and count > els_p.

Reset
REQ-028 While reset_i=1 at a clock edge, the pointers and count SHALL be 0.
REQ-029 Outputs after reset SHALL be v_o=0, ready_o=1 and count_o=0.
REQ-030 Storage contents SHALL NOT be reset, and data_o is don't-care while v_o=0.
REQ-031 Reset asserted mid-operation SHALL discard all entries, exactly like clr_i, and any same-cycle enq/deq SHALL be ignored.

Configuration
REQ-032 Macro BP_FE_QUEUE_BYPASS_EN, when defined: with count=0 and v_i=1, v_o SHALL be 1 and data_o SHALL equal data_i in the same cycle.
REQ-033 With BP_FE_QUEUE_BYPASS_EN defined, if yumi_i is also 1 in that bypass cycle, the message SHALL NOT be stored and count SHALL stay 0; otherwise it is stored normally.
REQ-034 With BP_FE_QUEUE_BYPASS_EN defined, clr_i=1 in a bypass cycle SHALL force v_o to 0.
REQ-035 When BP_FE_QUEUE_BYPASS_EN is undefined, no combinational path SHALL exist from v_i/data_i to v_o/data_o.

Verification (els_p=4, width_p=128)
REQ-036 Fill/drain: enqueue 0x1..0x4 on cycles 0-3 with yumi_i=0 -> ready_o=0 and count_o=4 at cycle 4; then yumi_i=1 for 4 cycles -> data_o sequence 0x1,0x2,0x3,0x4 and final v_o=0.
REQ-037 Full plus simultaneous: queue full, v_i=1 (0x5) with yumi_i=1 -> 0x1 dequeued, 0x5 not accepted, count_o=3, ready_o=1 next cycle.
REQ-038 Wrap-around: 10 single enqueue/dequeue pairs, values 0x10..0x19 -> outputs in order, with pointers wrapping twice.
REQ-039 Flush: count=3, clr_i=1 with v_i=1 (0xAA) and yumi_i=1 -> next cycle count_o=0, v_o=0, and 0xAA is never observed.
REQ-040 Bypass (macro defined): empty queue, v_i=1 (0x77), yumi_i=1 -> same-cycle v_o=1 and data_o=0x77, count_o stays 0; with the macro undefined -> v_o=0 that cycle and 0x77 appears the next cycle.
REQ-041 Reset mid-run: count=2 and reset_i=1 for 1 cycle -> v_o=0, ready_o=1, count_o=0.

Source files
------------

// File: rtl/bp_fe_queue_fifo.sv
// bp_fe_queue_fifo: circular-buffer FIFO between pc_gen and the FE queue consumer.
// The buffer holds els_p messages of width_p bits. Full and empty are told apart
// by an explicit occupancy count, so the read and write pointers may be equal in
// both cases.
// ready_o depends only on registered state. clr_i flushes the queue and takes
// priority over any enqueue or dequeue requested in the same cycle.
// Optional feature macro: BP_FE_QUEUE_BYPASS_EN. When it is defined, a message
// arriving at an empty queue is presented on data_o in the same cycle. If the
// consumer takes it in that cycle, the message is never written into storage.
// With the macro undefined, there is no combinational path from the input side
// to the output side.
// els_p must be a power of two and at least 2, so that the pointers wrap naturally.

module bp_fe_queue_fifo #(
    parameter int els_p   = 8,
    parameter int width_p = 128
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         clr_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         v_i,
    output logic                         ready_o,
    output logic [width_p-1:0]           data_o,
    output logic                         v_o,
    input  logic                         yumi_i,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int PtrW = $clog2(els_p);
    localparam int CntW = $clog2(els_p + 1);

    localparam logic [CntW-1:0] FullCount = CntW'(els_p);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

    logic [width_p-1:0] r_mem [els_p];
    logic [PtrW-1:0]    r_wptr;
    logic [PtrW-1:0]    r_rptr;
    logic [CntW-1:0]    r_count;

    logic               w_notEmpty;
    logic               w_full;
    logic               w_enq;
    logic               w_deq;
    logic [width_p-1:0] w_headData;

    // Occupancy flags and the ready signal, all derived from registered state only
    always_comb begin
        w_notEmpty = (r_count != '0);
        w_full     = (r_count == FullCount);
        ready_o    = ~w_full;
        count_o    = r_count;
        w_headData = r_mem[r_rptr];
    end

`ifdef BP_FE_QUEUE_BYPASS_EN
    logic w_bypass;

    // Forward an incoming message straight to the output when the queue is empty;
    // a message consumed in the same cycle is not stored
    always_comb begin
        w_bypass = ~w_notEmpty & v_i & ~clr_i;
        v_o      = w_notEmpty | w_bypass;
        data_o   = w_bypass ? data_i : w_headData;
        w_enq    = v_i & ready_o & ~clr_i & ~(w_bypass & yumi_i);
        w_deq    = yumi_i & w_notEmpty & ~clr_i;
    end
`else
    // Output side sees stored entries only; the enqueue and dequeue strobes are
    // masked by the flush request
    always_comb begin
        v_o    = w_notEmpty;
        data_o = w_headData;
        w_enq  = v_i & ready_o & ~clr_i;
        w_deq  = yumi_i & w_notEmpty & ~clr_i;
    end
`endif

    // Write the accepted message into the slot at the write pointer (storage itself is never reset)
    always_ff @(posedge clk_i) begin
        if (w_enq && !reset_i) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // Advance the pointers and the occupancy count; reset and flush both empty the queue
    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + PtrOne;
            end
            if (w_deq) begin
                r_rptr <= r_rptr + PtrOne;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CntOne;
                2'b01:   r_count <= r_count - CntOne;
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Flag a consumer taking data that is not valid, and an impossible occupancy value
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o));
            assert (r_count <= FullCount);
        end
    end
`endif

endmodule

// File: tb/tb_bp_fe_queue_fifo.sv
// tb_bp_fe_queue_fifo: directed bench for bp_fe_queue_fifo with els_p=4, width_p=128.
// It runs a table of single-cycle vectors and then hand-written multi-cycle sequences.
// The bypass expectations follow BP_FE_QUEUE_BYPASS_EN.

module tb_bp_fe_queue_fifo;

    localparam int Els   = 4;
    localparam int Width = 128;
    localparam int CntW  = $clog2(Els + 1);

    logic             clock;
    logic             reset;
    logic             clr;
    logic [Width-1:0] dataIn;
    logic             vIn;
    logic             ready;
    logic [Width-1:0] dataOut;
    logic             vOut;
    logic             yumi;
    logic [CntW-1:0]  count;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic             rst;
        logic             clr;
        logic             v;
        logic [Width-1:0] data;
        logic             yumi;
        logic             expReady;
        logic             expV;
        logic [CntW-1:0]  expCount;
        logic [Width-1:0] expData;
    } vec_t;

    vec_t vecs[16];

    bp_fe_queue_fifo #(
        .els_p   (Els),
        .width_p (Width)
    ) dut (
        .clk_i   (clock),
        .reset_i (reset),
        .clr_i   (clr),
        .data_i  (dataIn),
        .v_i     (vIn),
        .ready_o (ready),
        .data_o  (dataOut),
        .v_o     (vOut),
        .yumi_i  (yumi),
        .count_o (count)
    );

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic r, input logic c, input logic v,
                                 input logic [Width-1:0] d, input logic y);
        reset  = r;
        clr    = c;
        vIn    = v;
        dataIn = d;
        yumi   = y;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [Width-1:0] actual,
                               input logic [Width-1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic setVec(input int i, input logic r, input logic c, input logic v,
                          input logic [Width-1:0] d, input logic y, input logic er,
                          input logic ev, input logic [CntW-1:0] ec,
                          input logic [Width-1:0] ed);
        vecs[i].rst      = r;
        vecs[i].clr      = c;
        vecs[i].v        = v;
        vecs[i].data     = d;
        vecs[i].yumi     = y;
        vecs[i].expReady = er;
        vecs[i].expV     = ev;
        vecs[i].expCount = ec;
        vecs[i].expData  = ed;
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);

        //     idx rst clr v   data     yumi  rdy  v    cnt  data
        setVec(0,  1,  0,  0,  'h0,     0,    1,   0,   0,   'h0);
        setVec(1,  0,  0,  1,  'h1,     0,    1,   1,   1,   'h1);
        setVec(2,  0,  0,  1,  'h2,     0,    1,   1,   2,   'h1);
        setVec(3,  0,  0,  1,  'h3,     0,    1,   1,   3,   'h1);
        setVec(4,  0,  0,  1,  'h4,     0,    0,   1,   4,   'h1);
        setVec(5,  0,  0,  1,  'h9,     0,    0,   1,   4,   'h1);
        setVec(6,  0,  0,  1,  'h5,     1,    1,   1,   3,   'h2);
        setVec(7,  0,  0,  1,  'h6,     1,    1,   1,   3,   'h3);
        setVec(8,  0,  0,  0,  'h0,     1,    1,   1,   2,   'h4);
        setVec(9,  0,  1,  1,  'hAA,    1,    1,   0,   0,   'h0);
        setVec(10, 0,  0,  1,  'h21,    0,    1,   1,   1,   'h21);
        setVec(11, 0,  0,  1,  'h22,    0,    1,   1,   2,   'h21);
        setVec(12, 1,  0,  1,  'h23,    1,    1,   0,   0,   'h0);
        setVec(13, 0,  0,  0,  'h0,     0,    1,   0,   0,   'h0);
        setVec(14, 0,  0,  1,  'h31,    0,    1,   1,   1,   'h31);
        setVec(15, 0,  0,  0,  'h0,     1,    1,   0,   0,   'h0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].v, vecs[i].data, vecs[i].yumi);
            stepCycle();
            checkOutput($sformatf("vec%0d ready", i), {127'b0, ready}, {127'b0, vecs[i].expReady});
            checkOutput($sformatf("vec%0d v_o", i), {127'b0, vOut}, {127'b0, vecs[i].expV});
            checkOutput($sformatf("vec%0d count", i), {125'b0, count}, {125'b0, vecs[i].expCount});
            if (vecs[i].expV) begin
                checkOutput($sformatf("vec%0d data", i), dataOut, vecs[i].expData);
            end
        end

        // Fill then drain, checking the head before each dequeue
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        stepCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, Width'(i + 1), 1'b0);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("fill ready", {127'b0, ready}, 128'h0);
        checkOutput("fill count", {125'b0, count}, 128'h4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
            #2;
            checkOutput($sformatf("drain%0d v_o", i), {127'b0, vOut}, 128'h1);
            checkOutput($sformatf("drain%0d data", i), dataOut, Width'(i + 1));
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("drain final v_o", {127'b0, vOut}, 128'h0);
        checkOutput("drain final count", {125'b0, count}, 128'h0);

        // Wrap-around: ten enqueue/dequeue pairs take the pointers around twice
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, Width'(16 + i), 1'b0);
            stepCycle();
            checkOutput($sformatf("wrap%0d data", i), dataOut, Width'(16 + i));
            checkOutput($sformatf("wrap%0d count", i), {125'b0, count}, 128'h1);
            applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
            stepCycle();
            checkOutput($sformatf("wrap%0d empty", i), {127'b0, vOut}, 128'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Flush with a same-cycle enqueue and dequeue; the flushed message never appears
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, Width'(65 + i), 1'b0);
            stepCycle();
        end
        checkOutput("flush pre count", {125'b0, count}, 128'h3);
        applyStimulus(1'b0, 1'b1, 1'b1, Width'(170), 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("flush count", {125'b0, count}, 128'h0);
        checkOutput("flush v_o", {127'b0, vOut}, 128'h0);
        checkOutput("flush ready", {127'b0, ready}, 128'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, Width'(85), 1'b0);
        stepCycle();
        checkOutput("post-flush head", dataOut, Width'(85));
        checkOutput("post-flush count", {125'b0, count}, 128'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("post-flush empty", {127'b0, vOut}, 128'h0);

        // Message arriving at an empty queue
`ifdef BP_FE_QUEUE_BYPASS_EN
        applyStimulus(1'b0, 1'b0, 1'b1, Width'(119), 1'b1);
        #2;
        checkOutput("bypass same-cycle v_o", {127'b0, vOut}, 128'h1);
        checkOutput("bypass same-cycle data", dataOut, Width'(119));
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("bypass count", {125'b0, count}, 128'h0);
        checkOutput("bypass v_o after", {127'b0, vOut}, 128'h0);
`else
        applyStimulus(1'b0, 1'b0, 1'b1, Width'(119), 1'b0);
        #2;
        checkOutput("nobypass same-cycle v_o", {127'b0, vOut}, 128'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("nobypass next v_o", {127'b0, vOut}, 128'h1);
        checkOutput("nobypass next data", dataOut, Width'(119));
        checkOutput("nobypass count", {125'b0, count}, 128'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("nobypass drained", {127'b0, vOut}, 128'h0);
`endif

        stepCycle();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
